// File: rtl/drate.sv
// Decimating boxcar rate converter: averages R = F_H/F_L consecutive signed
// 16-bit samples and emits the mean at F_L with a one-cycle strobe.
module drate #(
    parameter int unsigned F_H = 60,
    parameter int unsigned F_L = 3,
    parameter int unsigned SH  = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] in,
    input  logic               sync,
    output logic signed [15:0] out,
    output logic               out_stb,
    output logic [7:0]         phase
);

    localparam int unsigned R  = F_H / F_L;
    localparam int unsigned AW = 16 + $clog2(R);
    localparam int unsigned RW = SH + 2;
    localparam int unsigned PW = AW + RW;

    // Reciprocal is rounded to nearest so that exact multiples average exactly.
    localparam logic signed [PW-1:0] RECIP =
        PW'(((64'd1 << SH) + 64'(R / 2)) / 64'(R));
    localparam logic signed [PW-1:0] RND  = PW'(64'd1 << (SH - 1));
    localparam logic signed [PW-1:0] MAXV = PW'(32767);
    localparam logic signed [PW-1:0] MINV = ~MAXV;

    if (F_L == 0 || (F_H % F_L) != 0 || R < 2 || R > 256) begin : g_bad_ratio
        $error("drate: F_H/F_L must be an integer in [2,256]");
    end
    if (SH < 1 || SH > 40) begin : g_bad_shift
        $error("drate: SH must be in [1,40]");
    end

    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [AW-1:0] sum_q, sum_d;
    logic [7:0]           phase_q, phase_d;
    logic                 v1_q, v1_d;
    logic signed [PW-1:0] prod_q, prod_d;
    logic                 v2_q, v2_d;
    logic signed [15:0]   out_q, out_d;
    logic                 stb_q, stb_d;

    logic signed [AW-1:0] in_ext;
    logic signed [PW-1:0] sum_ext;
    logic signed [PW-1:0] shifted;

    assign in_ext  = {{(AW-16){in[15]}}, in};
    assign sum_ext = {{(PW-AW){sum_q[AW-1]}}, sum_q};
    assign shifted = prod_q >>> SH;

    // Stage 0: accumulate; sync restarts the window and outranks completion.
    always_comb begin
        acc_d   = acc_q;
        sum_d   = sum_q;
        phase_d = phase_q;
        v1_d    = 1'b0;
        if (sync) begin
            acc_d   = '0;
            phase_d = '0;
        end else if (phase_q == 8'(R - 1)) begin
            sum_d   = acc_q + in_ext;
            v1_d    = 1'b1;
            acc_d   = '0;
            phase_d = '0;
        end else begin
            acc_d   = acc_q + in_ext;
            phase_d = phase_q + 8'd1;
        end
    end

    // Stage 1: scale by the reciprocal with a half-LSB rounding offset.
    always_comb begin
        prod_d = prod_q;
        v2_d   = v1_q;
        if (v1_q) begin
            prod_d = sum_ext * RECIP + RND;
        end
    end

    // Stage 2: drop fractional bits and saturate to 16 bits.
    always_comb begin
        out_d = out_q;
        stb_d = v2_q;
        if (v2_q) begin
            if (shifted > MAXV) begin
                out_d = 16'sh7FFF;
            end else if (shifted < MINV) begin
                out_d = 16'sh8000;
            end else begin
                out_d = shifted[15:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            sum_q   <= '0;
            phase_q <= '0;
            v1_q    <= 1'b0;
            prod_q  <= '0;
            v2_q    <= 1'b0;
            out_q   <= '0;
            stb_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            phase_q <= phase_d;
            v1_q    <= v1_d;
            prod_q  <= prod_d;
            v2_q    <= v2_d;
            out_q   <= out_d;
            stb_q   <= stb_d;
        end
    end

    assign out     = out_q;
    assign out_stb = stb_q;
    assign phase   = phase_q;

endmodule
